// File: rtl/signcorr_pkg.sv
// Shared types and constants for the sign correlator: FSM state encoding,
// the width helper used for CORR_W, and the +/-1 sample encodings.
package signcorr_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HUNT = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [1:0] POS_ONE = 2'b01;
  localparam logic [1:0] NEG_ONE = 2'b11;

  // Smallest r with 2**r >= value; usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count built as a balanced binary adder tree by
// recursively splitting the input vector in half.
module popcount_tree
  import signcorr_pkg::*;
#(
  parameter int N = 16,
  localparam int OUT_W = clog2(N + 1)
) (
  input  logic [N-1:0]     bits,
  output logic [OUT_W-1:0] count
);

  if (N == 1) begin : g_leaf
    assign count = bits;
  end else begin : g_node
    localparam int LO_N = N / 2;
    localparam int HI_N = N - LO_N;
    localparam int LO_W = clog2(LO_N + 1);
    localparam int HI_W = clog2(HI_N + 1);

    logic [LO_W-1:0] lo_count;
    logic [HI_W-1:0] hi_count;

    popcount_tree #(.N(LO_N)) u_lo (.bits(bits[LO_N-1:0]), .count(lo_count));
    popcount_tree #(.N(HI_N)) u_hi (.bits(bits[N-1:LO_N]), .count(hi_count));

    assign count = OUT_W'(lo_count) + OUT_W'(hi_count);
  end

endmodule

// File: rtl/sign_correlator.sv
// Sliding-window sign correlator with threshold/holdoff sync detection.
// Define SIGNCORR_BIPOLAR_EN to detect on |corr| and report match polarity.
module sign_correlator
  import signcorr_pkg::*;
#(
  parameter int SAMPLE_W = 2,
  parameter int TAPS     = 16,
  parameter int HOLDOFF  = 32,
  localparam int CORR_W  = clog2(TAPS + 1) + 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [SAMPLE_W-1:0]      i_sample,
  input  logic [TAPS-1:0]          i_pattern,
  input  logic signed [CORR_W-1:0] i_threshold,
  input  logic                     i_clear,
  output logic signed [CORR_W-1:0] o_corr,
  output logic                     o_corr_valid,
  output logic                     o_sync,
  output logic                     o_locked,
  output logic                     o_polarity
);

  localparam int FILL_W = clog2(TAPS + 1);
  localparam int HOLD_W = clog2(HOLDOFF + 1);

  logic [TAPS-1:0]          window;
  logic [TAPS-1:0]          mism;
  logic [FILL_W-1:0]        fill;
  logic [FILL_W-1:0]        mism_count;
  logic [HOLD_W-1:0]        holdoff;
  logic                     upd;
  logic                     v1;
  logic                     full;
  logic                     hit;
  logic                     hold_load;
  logic                     hold_dec;
  logic signed [CORR_W-1:0] corr_next;
  state_t                   state;
  state_t                   state_next;

  // Only the sign bit of each sample carries information.
  logic unused_sample_bits;
  assign unused_sample_bits = ^i_sample[SAMPLE_W-2:0];

  assign full = (fill == FILL_W'(TAPS));

  // NOTE: non-blocking assignments so each stage reads the previous cycle's value of the one before it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      window <= '0;
      fill   <= '0;
      upd    <= 1'b0;
    end else if (i_clear) begin
      window <= '0;
      fill   <= '0;
      upd    <= 1'b0;
    end else begin
      upd <= i_valid;
      if (i_valid) begin
        window <= {window[TAPS-2:0], i_sample[SAMPLE_W-1]};
        if (!full) fill <= fill + 1'b1;
      end
    end
  end

  // Stage 1: per-tap mismatch (XOR of signs is the inverted sign product).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mism <= '0;
      v1   <= 1'b0;
    end else begin
      mism <= window ^ i_pattern;
      v1   <= upd && full && !i_clear;
    end
  end

  popcount_tree #(.N(TAPS)) u_popcount (.bits(mism), .count(mism_count));

  // Each mismatch turns a +1 product into -1.
  assign corr_next = CORR_W'(TAPS) - {mism_count, 1'b0};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_corr       <= '0;
      o_corr_valid <= 1'b0;
    end else if (i_clear) begin
      o_corr_valid <= 1'b0;
    end else begin
      o_corr_valid <= v1;
      if (v1) o_corr <= corr_next;
    end
  end

`ifdef SIGNCORR_BIPOLAR_EN
  logic signed [CORR_W-1:0] corr_mag;
  logic                     pol_q;

  assign corr_mag = o_corr[CORR_W-1] ? -o_corr : o_corr;
  assign hit      = (corr_mag >= i_threshold);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       pol_q <= 1'b0;
    else if (i_clear) pol_q <= 1'b0;
    else if (o_sync)  pol_q <= o_corr[CORR_W-1];
  end

  assign o_polarity = o_sync ? o_corr[CORR_W-1] : pol_q;
`else
  assign hit        = (o_corr >= i_threshold);
  assign o_polarity = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= FILL;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    o_sync     = 1'b0;
    o_locked   = 1'b0;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    unique case (state)
      FILL: if (full) state_next = HUNT;
      HUNT: begin
        if (o_corr_valid && hit) begin
          o_sync     = 1'b1;
          hold_load  = 1'b1;
          state_next = LOCK;
        end
      end
      LOCK: begin
        o_locked = 1'b1;
        if (o_corr_valid) begin
          hold_dec = 1'b1;
          if (holdoff == HOLD_W'(1)) state_next = HUNT;
        end
      end
      default: state_next = FILL;
    endcase
    if (i_clear) state_next = FILL;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          holdoff <= '0;
    else if (i_clear)   holdoff <= '0;
    else if (hold_load) holdoff <= HOLD_W'(HOLDOFF);
    else if (hold_dec)  holdoff <= holdoff - 1'b1;
  end

endmodule

// File: tb/tb_sign_correlator.sv
// Self-checking bench for sign_correlator (TAPS=8, HOLDOFF=4): vector table,
// directed corner sequences and randomized traffic against a queue-based model.
module tb_sign_correlator;
  import signcorr_pkg::*;

  localparam int SAMPLE_W = 2;
  localparam int TAPS     = 8;
  localparam int HOLDOFF  = 4;
  localparam int CORR_W   = clog2(TAPS + 1) + 1;

`ifdef SIGNCORR_BIPOLAR_EN
  localparam bit BIPOLAR = 1'b1;
`else
  localparam bit BIPOLAR = 1'b0;
`endif

  typedef struct { int due; int corr; } result_t;
  typedef struct {
    bit v; bit neg; bit clr;
    bit e_valid; int e_corr; bit e_sync; bit e_locked;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     valid;
  logic                     clear;
  logic [SAMPLE_W-1:0]      sample;
  logic [TAPS-1:0]          pattern;
  logic signed [CORR_W-1:0] threshold;
  logic signed [CORR_W-1:0] corr;
  logic                     corr_valid;
  logic                     sync;
  logic                     locked;
  logic                     polarity;

  sign_correlator #(.SAMPLE_W(SAMPLE_W), .TAPS(TAPS), .HOLDOFF(HOLDOFF)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sample(sample),
    .i_pattern(pattern), .i_threshold(threshold), .i_clear(clear),
    .o_corr(corr), .o_corr_valid(corr_valid), .o_sync(sync),
    .o_locked(locked), .o_polarity(polarity)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_accept = 0;

  // Reference model: accepted signs (newest at back), results in flight, lock state.
  bit      hist[$];
  result_t pend[$];
  int      m_corr   = 0;
  bit      m_locked = 1'b0;
  int      m_hold   = 0;
  bit      m_pol    = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic model_reset();
    hist.delete();
    pend.delete();
    m_corr   = 0;
    m_locked = 1'b0;
    m_hold   = 0;
    m_pol    = 1'b0;
  endtask

  // Correlation of the last TAPS accepted signs; window position 0 is newest.
  function automatic int window_corr();
    int c = 0;
    for (int i = 0; i < TAPS; i++)
      c += (hist[TAPS-1-i] == pattern[i]) ? 1 : -1;
    return c;
  endfunction

  function automatic bit model_hit(input int c);
    int mag = (BIPOLAR && c < 0) ? -c : c;
    return mag >= int'(threshold);
  endfunction

  // One clock: drive inputs, advance, then compare every output to the model.
  task automatic step(input bit v, input bit neg, input bit clr);
    result_t r;
    bit e_valid, e_sync, e_locked;
    valid  = v;
    sample = neg ? NEG_ONE : POS_ONE;
    clear  = clr;
    @(posedge clk);
    #1;
    cyc++;
    e_valid  = 1'b0;
    e_sync   = 1'b0;
    e_locked = clr ? 1'b0 : m_locked;
    if (clr) begin
      hist.delete();
      pend.delete();
      m_locked = 1'b0;
      m_hold   = 0;
      m_pol    = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r       = pend.pop_front();
        e_valid = 1'b1;
        m_corr  = r.corr;
        if (m_locked) begin
          m_hold--;
          if (m_hold == 0) m_locked = 1'b0;
        end else if (model_hit(r.corr)) begin
          e_sync   = 1'b1;
          m_pol    = (r.corr < 0);
          m_locked = 1'b1;
          m_hold   = HOLDOFF;
        end
      end
      if (v) begin
        hist.push_back(neg);
        if (hist.size() > TAPS) void'(hist.pop_front());
        if (hist.size() == TAPS) pend.push_back('{due: cyc + 2, corr: window_corr()});
        last_accept = cyc;
      end
    end
    check("corr_valid", corr_valid, e_valid);
    check("corr", corr, m_corr);
    check("sync", sync, e_sync);
    check("locked", locked, e_locked);
    check("polarity", polarity, BIPOLAR ? m_pol : 1'b0);
  endtask

  initial begin
    vec_t vecs[11];
    int   n_valid;
    int   n_sync;
    int   seq_a[$];
    int   seq_b[$];

    rst       = 1'b1;
    valid     = 1'b0;
    clear     = 1'b0;
    sample    = POS_ONE;
    pattern   = 8'b1011_0010;
    threshold = CORR_W'(6);
    #12;
    check("reset_corr", corr, 0);
    check("reset_valid", corr_valid, 0);
    check("reset_sync", sync, 0);
    check("reset_locked", locked, 0);
    check("reset_polarity", polarity, 0);
    @(negedge clk);
    rst = 1'b0;

    // Match detection: pattern sent MSB first, result two edges after the 8th sample.
    for (int i = 0; i < TAPS; i++) vecs[i] = '{1'b1, pattern[TAPS-1-i], 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0,    1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, TAPS, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, TAPS, 1'b0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].v, vecs[i].neg, vecs[i].clr);
      check($sformatf("vec%0d_valid", i), corr_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_corr", i), corr, vecs[i].e_corr);
      check($sformatf("vec%0d_sync", i), sync, vecs[i].e_sync);
      check($sformatf("vec%0d_locked", i), locked, vecs[i].e_locked);
    end

    // Inverted stream.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < TAPS; i++) step(1'b1, !pattern[TAPS-1-i], 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("inv_valid", corr_valid, 1);
    check("inv_corr", corr, -TAPS);
    check("inv_sync", sync, BIPOLAR);
    check("inv_polarity", polarity, BIPOLAR);

    // Holdoff with the pattern repeated back to back: syncs on results 0, 8 and 16.
    step(1'b0, 1'b0, 1'b1);
    n_sync = 0;
    for (int i = 0; i < 3 * TAPS; i++) begin
      step(1'b1, pattern[TAPS-1-(i%TAPS)], 1'b0);
      n_sync += sync;
      if (i == 13) check("holdoff_locked_last", locked, 1);
      if (i == 14) check("holdoff_unlocked", locked, 0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_sync += sync;
    end
    check("holdoff_sync_count", n_sync, 3);

    // Clear concurrent with a sample: that sample is dropped, refill needs 8 more.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, pattern[TAPS-1-i], 1'b0);
    step(1'b1, 1'b1, 1'b1);
    n_valid = 0;
    for (int i = 0; i < TAPS; i++) begin
      step(1'b1, pattern[TAPS-1-i], 1'b0);
      n_valid += corr_valid;
    end
    step(1'b0, 1'b0, 1'b0);
    n_valid += corr_valid;
    check("clear_no_early_result", n_valid, 0);
    step(1'b0, 1'b0, 1'b0);
    check("clear_first_result", corr_valid, 1);
    check("clear_first_corr", corr, TAPS);

    // Gapped input must reproduce the back-to-back correlation sequence.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * TAPS; i++) begin
      step(1'b1, pattern[TAPS-1-(i%TAPS)], 1'b0);
      if (corr_valid) seq_a.push_back(int'(corr));
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (corr_valid) seq_a.push_back(int'(corr));
    end
    check("b2b_result_count", seq_a.size(), TAPS + 1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * TAPS; i++) begin
      for (int ph = 0; ph < 3; ph++) begin
        step(ph == 0, pattern[TAPS-1-(i%TAPS)], 1'b0);
        if (corr_valid) begin
          seq_b.push_back(int'(corr));
          check("gap_latency", cyc - last_accept, 2);
        end
      end
    end
    check("gap_result_count", seq_b.size(), seq_a.size());
    for (int k = 0; k < seq_a.size() && k < seq_b.size(); k++)
      check($sformatf("gap_corr%0d", k), seq_b[k], seq_a[k]);

    // Asynchronous reset mid-stream while a result and a sync are showing.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < TAPS + 2; i++) step(1'b1, pattern[TAPS-1-(i%TAPS)], 1'b0);
    check("pre_reset_valid", corr_valid, 1);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("mid_reset_corr", corr, 0);
    check("mid_reset_valid", corr_valid, 0);
    check("mid_reset_sync", sync, 0);
    check("mid_reset_locked", locked, 0);
    check("mid_reset_polarity", polarity, 0);
    @(negedge clk);
    rst = 1'b0;
    n_valid = 0;
    for (int i = 0; i < TAPS - 1; i++) begin
      step(1'b1, pattern[TAPS-1-i], 1'b0);
      n_valid += corr_valid;
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_valid += corr_valid;
    end
    check("post_reset_no_result", n_valid, 0);

    // Randomized traffic, including threshold extremes and occasional clears.
    for (int blk = 0; blk < 4; blk++) begin
      pattern = TAPS'($urandom);
      case (blk)
        0:       threshold = CORR_W'(-TAPS);
        1:       threshold = CORR_W'(TAPS + 1);
        default: threshold = CORR_W'(int'($urandom_range(0, 2 * TAPS)) - TAPS);
      endcase
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 150; i++)
        step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sign_correlator.md
Name: sign_correlator

Overview:
- Parametrised successor to the 2-bit sign-product cell in the Manchester sync path.
- Forms the full sliding-window correlation of the incoming ±1 sample stream against a TAPS-long reference pattern.
- Sign products are formed as XNOR of sign bits; products are summed by a pipelined popcount.
- Runs a threshold/holdoff FSM that emits a single sync pulse per detected preamble. Sits between the Manchester decoder sample output and the frame aligner.

Parameters:
- SAMPLE_W, 2, width of signed input sample; only MSB (sign) is used, bit=1 means -1.
- TAPS, 16, correlation window length (>=2).
- HOLDOFF, 32, number of o_corr_valid results suppressed after a sync before re-arming (>=1).
- CORR_W, $clog2(TAPS+1)+1, localparam, signed correlation width.

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  sample strobe; one sample accepted per cycle when high.
- i_sample  in  SAMPLE_W  signed sample (01=+1, 11=-1).
- i_pattern  in  TAPS  reference; bit[i] compares with window position i (bit=1 means -1); quasi-static.
- i_threshold  in  CORR_W  signed detection threshold.
- i_clear  in  1  synchronous flush of window, pipeline and FSM.
- o_corr  out  CORR_W  signed correlation, range -TAPS..+TAPS.
- o_corr_valid  out  1  one-cycle strobe per full-window result.
- o_sync  out  1  one-cycle pulse on detection; coincides with o_corr_valid.
- o_locked  out  1  high during holdoff.
- o_polarity  out  1  1 = detected match was inverted (see Optional Feature).

Behaviour:
- Reset (async, i_rst=1): window, fill counter, pipeline regs, holdoff counter = 0; state FILL; all outputs 0. Takes effect immediately mid-operation. Pipeline is fully flushed: no result is emitted for samples accepted before reset.
- Window: on i_valid, w <= {w[TAPS-2:0], i_sample[SAMPLE_W-1]}; w[0] is newest. The first-sent bit ends at w[TAPS-1].
- Fill counter: increments per accepted sample and saturates at TAPS.
- Stage 1: at edge after the window update, mism <= w ^ i_pattern; v1 <= (window update occurred && fill==TAPS).
- Stage 2: at the next edge, o_corr <= TAPS - 2*popcount(mism) (signed, no overflow by CORR_W sizing); o_corr_valid <= v1.
- Latency: sample accepted at edge k; result valid after edge k+2. Pipeline advances every cycle regardless of i_valid. Gaps in i_valid produce gaps in o_corr_valid only.
- o_corr holds its last value while o_corr_valid is low.
- FSM states:
  - FILL: exit to HUNT when fill reaches TAPS.
  - HUNT: on a stage-2 result with corr >= i_threshold (signed compare), assert o_sync together with o_corr_valid, load holdoff=HOLDOFF, go to LOCK.
  - LOCK: o_locked=1. Each o_corr_valid decrements holdoff and no o_sync is emitted. At 0, return to HUNT; the result that drives holdoff to 0 is itself not eligible for detection.
- Threshold <= -TAPS: every result in HUNT syncs. Threshold > TAPS: never syncs.
- i_clear: next edge zeroes window, fill, v1, o_corr_valid, holdoff and sets state FILL. o_corr retains its value. i_clear together with i_valid: clear wins and the sample is discarded.
- i_pattern change: takes effect on the next stage-1 capture; no flush.

Optional Feature:
- Macro SIGNCORR_BIPOLAR_EN.
- Defined: detection on |corr| >= i_threshold; o_polarity registered with o_sync (1 when corr<0), held until the next sync or clear.
- Undefined: positive-only detection; o_polarity tied 0.

Decomposition:
- Shared package/include signcorr_pkg holds:
  - FSM state encodings (FILL=2'd0, HUNT=2'd1, LOCK=2'd2).
  - CORR_W derivation helper (clog2 function).
  - Sample sign-encoding constants (POS_ONE=2'b01, NEG_ONE=2'b11).
- One sub-module: popcount_tree, parametrised on input width, purely combinational adder tree, instantiated in stage 2.

Test Plan:
- Reset: drive i_rst mid-stream with 5 samples in flight -> all outputs 0 immediately; no o_corr_valid for the following 7 samples after release (TAPS=8).
- Match detection: TAPS=8, pattern=8'b1011_0010, threshold=6, send pattern MSB-first as ±1 samples on consecutive cycles -> o_corr_valid and o_corr=+8 two cycles after 8th sample, o_sync=1 same cycle, o_locked=1 next cycle.
- Inverted stream, same setup -> o_corr=-8, no o_sync without macro. With SIGNCORR_BIPOLAR_EN -> o_sync=1, o_polarity=1.
- Holdoff: HOLDOFF=4, repeat pattern continuously -> exactly one o_sync; o_locked drops after the 4th result; next result >=6 syncs again.
- Clear: i_clear after 5 samples, concurrent with i_valid -> that sample dropped; first o_corr_valid only after 8 further samples.
- Gapped input: i_valid every 3rd cycle with the match stream -> identical o_corr sequence to the back-to-back case; each result lands 2 cycles after its sample.
